tick_divider: RTL
=================

TICK_DIVIDER -- requirements
Module: tick_divider

Interface
REQ-001 SHALL have parameter p_channels, default 4, number of independent tick channels (1..16).
REQ-002 SHALL have parameter p_width, default 26, width of each channel's divider value and counter.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port i_div, input, p_channels x p_width, per-channel period N in clock cycles.
REQ-006 SHALL have port i_oneshot, input, p_channels, per-channel mode: 0 = periodic, 1 = one-shot.
REQ-007 SHALL have port i_start, input, p_channels, per-channel start/restart request, level-sampled.
REQ-008 SHALL have port i_stop, input, p_channels, per-channel pause while high.
REQ-009 SHALL have port i_clear, input, p_channels, per-channel abort to idle.
REQ-010 SHALL have port o_tick, output, p_channels, per-channel one-cycle tick pulse, registered.
REQ-011 SHALL have port o_running, output, p_channels, high while the channel is in RUN or PAUSE.
REQ-012 SHALL have port o_any_tick, output, 1, registered OR of all o_tick bits in the same cycle.

Function
REQ-013 SHALL implement per channel a state machine with states IDLE, RUN and PAUSE, plus a p_width down-counter cnt.
REQ-014 SHALL apply per-channel input priority i_clear > i_stop > i_start > count.
REQ-015 SHALL, on i_clear in any state, go to IDLE with cnt = 0 and o_tick = 0 on the next edge.
REQ-016 SHALL, on i_start in IDLE or RUN with i_div != 0 and i_stop low, load cnt = i_div-1 and enter RUN; a start in RUN restarts the period.
REQ-017 SHALL ignore i_start when i_div == 0; the channel stays in, or returns to, IDLE.
REQ-018 SHALL, in RUN with cnt != 0, decrement cnt and drive o_tick = 0.
REQ-019 SHALL, in RUN with cnt == 0, drive o_tick = 1 for one cycle and reload cnt = i_div-1 from i_div sampled that cycle.
REQ-020 SHALL make a changed i_div take effect only at the next reload, never mid-period.
REQ-021 SHALL, at the reload edge, go to IDLE if the sampled i_oneshot = 1 or the sampled i_div = 0; otherwise stay in RUN.
REQ-022 SHALL place the first tick exactly N edges after the edge that samples i_start, then one tick every N cycles; with N = 1 periodic, o_tick stays continuously high.
REQ-023 SHALL, on i_stop in RUN, enter PAUSE, freeze cnt and drive o_tick = 0; a tick due that cycle is deferred, not lost.
REQ-024 SHALL, in PAUSE with i_stop low, return to RUN with cnt unchanged, without requiring i_start.
REQ-025 SHALL ignore i_stop in IDLE.
REQ-026 SHALL operate all channels independently, with no shared counters or arbitration.

Reset
REQ-027 SHALL, on i_rst, put every channel in IDLE with cnt = 0, o_tick = 0, o_running = 0 and o_any_tick = 0 on the next edge.
REQ-028 SHALL let i_rst override all other inputs and abort any period in progress.
REQ-029 SHALL define power-up initial values equal to the reset values.

Structure
REQ-030 SHALL place the channel state enum (IDLE, RUN, PAUSE) and the mode encoding constants in shared package tick_pkg.
REQ-031 SHALL implement one channel as sub-module tick_channel (parameter p_width), instantiated p_channels times by a generate loop.
REQ-032 SHALL form o_any_tick in the top level and register it there.

Verification
REQ-033 SHALL cover: ch0 i_div = 5, periodic, i_start pulsed at edge 0 -> o_tick[0] high after edges 5, 10 and 15 only.
REQ-034 SHALL cover: ch1 i_div = 3, one-shot, start -> exactly one tick after edge 3, then o_running[1] = 0 and no further ticks.
REQ-035 SHALL cover: ch0 i_div = 4, i_stop high for 3 cycles starting when cnt = 0 -> no tick during the stop, tick on the first edge after release, next period 4 cycles.
REQ-036 SHALL cover: ch2 running with i_div = 6, i_div changed to 2 mid-period -> current period completes at 6, following periods are 2.
REQ-037 SHALL cover: i_clear and i_start together on ch3, and i_start with i_div = 0 -> channel stays IDLE with no tick.
REQ-038 SHALL cover: i_rst asserted with all 4 channels running -> all outputs 0 next cycle; i_div = 1 periodic restart -> o_tick continuously high.

Source files
------------

// File: rtl/tick_pkg.sv
// Shared definitions for the tick divider: channel state encoding and
// the per-channel mode encoding used on the one-shot select input.
package tick_pkg;

  // Channel state. RUN and PAUSE both count as "running" to the outside.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } tick_state_t;

  // Mode encoding for the one-shot select input.
  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // Limits on the number of channels the top level accepts.
  localparam int MIN_CHANNELS = 1;
  localparam int MAX_CHANNELS = 16;

  // True when a channel in the given state is reported as running.
  function automatic logic state_is_running(input tick_state_t st);
    return (st == ST_RUN) || (st == ST_PAUSE);
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One independent tick channel: IDLE/RUN/PAUSE state machine plus a
// down-counter. The first tick lands N edges after the edge that samples
// start, and then every N cycles while periodic. The divider value is only
// sampled on start and at each reload, so a change never shortens or
// stretches the period already in progress.
module tick_channel
  import tick_pkg::*;
#(
  parameter int p_width = 26
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [p_width-1:0] div,
  input  logic               oneshot,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  output logic               tick,
  output logic               running,
  output logic               tick_next
);

  tick_state_t        state  = ST_IDLE;
  logic [p_width-1:0] cnt    = '0;
  logic               tick_q = 1'b0;

  logic div_zero;
  logic cnt_zero;
  logic reload_idle;
  logic fire;

  assign div_zero    = (div == '0);
  assign cnt_zero    = (cnt == '0);
  // At a reload edge the channel drops to IDLE in one-shot mode or when
  // the freshly sampled divider is zero (no valid period to reload).
  assign reload_idle = (oneshot == MODE_ONESHOT) || div_zero;

  // A tick is produced only from RUN at terminal count when nothing of
  // higher priority (clear, stop, restart) claims this edge; a stop here
  // leaves cnt at zero so the tick is emitted after the pause instead.
  always_comb begin
    fire = 1'b0;
    if (state == ST_RUN && cnt_zero && !clear && !stop && !start) begin
      fire = 1'b1;
    end
  end

  // Next-cycle tick value, exposed so the top can register the OR of all
  // channels in the same cycle as the individual tick outputs.
  assign tick_next = fire;

  // Channel state machine with priority reset > clear > stop > start > count.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= fire;
      case (state)
        ST_IDLE: begin
          // Stop high in IDLE has no effect beyond blocking a start.
          if (!stop && start && !div_zero) begin
            cnt   <= div - 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_PAUSE;
          end else if (start) begin
            if (!div_zero) begin
              cnt <= div - 1'b1;
            end else begin
              cnt   <= '0;
              state <= ST_IDLE;
            end
          end else if (cnt_zero) begin
            if (reload_idle) begin
              cnt   <= '0;
              state <= ST_IDLE;
            end else begin
              cnt <= div - 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_PAUSE: begin
          // Resume with the frozen count; a start is not needed and is
          // not treated as a restart while paused.
          if (!stop) begin
            state <= ST_RUN;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tick    = tick_q;
  assign running = state_is_running(state);

endmodule

// File: rtl/tick_divider.sv
// Multi-channel tick divider. Each channel is an independent tick_channel;
// the top only fans the per-channel buses out and registers the combined
// "any channel ticked" flag aligned with the individual tick outputs.
module tick_divider
  import tick_pkg::*;
#(
  parameter int p_channels = 4,
  parameter int p_width    = 26
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [p_channels-1:0][p_width-1:0]  i_div,
  input  logic [p_channels-1:0]               i_oneshot,
  input  logic [p_channels-1:0]               i_start,
  input  logic [p_channels-1:0]               i_stop,
  input  logic [p_channels-1:0]               i_clear,
  output logic [p_channels-1:0]               o_tick,
  output logic [p_channels-1:0]               o_running,
  output logic                                o_any_tick
);

  logic [p_channels-1:0] tick_next;
  logic                  any_q = 1'b0;

  // One channel instance per bit of the per-channel buses.
  for (genvar g = 0; g < p_channels; g++) begin : g_ch
    tick_channel #(
      .p_width (p_width)
    ) u_ch (
      .clk       (i_clk),
      .rst       (i_rst),
      .div       (i_div[g]),
      .oneshot   (i_oneshot[g]),
      .start     (i_start[g]),
      .stop      (i_stop[g]),
      .clear     (i_clear[g]),
      .tick      (o_tick[g]),
      .running   (o_running[g]),
      .tick_next (tick_next[g])
    );
  end

  // Register the OR of the next-cycle ticks so the flag lines up with o_tick.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |tick_next;
    end
  end

  assign o_any_tick = any_q;

endmodule
